// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single memory port between the 6502 core and a secondary DMA
//   requester. The CPU owns the bus by default. DMA steals cycles by pulling
//   cpu_rdy low. Bursts are capped at MAX_BURST beats, and each grant is
//   followed by COOL_CYCLES CPU-only cycles so the core is never starved.
//
//   Ports
//     ph1        in   clock, all state changes on the rising edge
//     reset      in   asynchronous active-low reset
//     cpu_addr   in   core address
//     cpu_wdata  in   core write data
//     cpu_we     in   core write strobe (core writes cannot be stalled)
//     cpu_rdata  out  memory read data to the core (pass-through)
//     cpu_rdy    out  registered; 0 = core holds its current read cycle
//     dma_req    in   level request, held with addr/data until dma_ack
//     dma_addr   in   DMA address
//     dma_wdata  in   DMA write data
//     dma_we     in   DMA write strobe
//     dma_ack    out  DMA transfer completes this cycle
//     dma_rdata  out  memory read data to DMA, valid while dma_ack=1
//     mem_addr   out  muxed memory address
//     mem_wdata  out  muxed memory write data
//     mem_we     out  muxed memory write strobe
//     mem_rdata  in   memory read data (combinational read)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_CPU  | CPU owns the bus; a DMA request moves to S_DMA
//   S_DMA  | DMA granted; CPU stalled unless it is mid-write
//   S_COOL | forced CPU-only cycles after a grant; DMA request ignored

module mem_bus_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_BURST   = 4,
  parameter int COOL_CYCLES = 1
) (
  input  logic                  ph1,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_we,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rdy,
  input  logic                  dma_req,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  input  logic                  dma_we,
  output logic                  dma_ack,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int CW = $clog2(COOL_CYCLES + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [CW-1:0] COOL_LOAD  = CW'(COOL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_CPU  = 2'd0,
    S_DMA  = 2'd1,
    S_COOL = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   burst_cnt, burst_nxt;
  logic [CW-1:0]   cool_cnt, cool_nxt;
  logic            sel_dma;

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state     <= S_CPU;
      burst_cnt <= '0;
      cool_cnt  <= '0;
      cpu_rdy   <= 1'b1;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      cool_cnt  <= cool_nxt;
      // Registered copy of "next state is not S_DMA" so cpu_rdy is a clean flop.
      cpu_rdy   <= (state_nxt != S_DMA);
    end
  end

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    cool_nxt  = cool_cnt;
    case (state)
      S_CPU: begin
        if (dma_req) begin
          state_nxt = S_DMA;
          burst_nxt = '0;
        end
      end
      S_DMA: begin
        if (!dma_req) begin
          // Requester released (either done or aborted without an ack).
          state_nxt = S_COOL;
          cool_nxt  = COOL_LOAD;
        end else if (!cpu_we) begin
          burst_nxt = burst_cnt + BW'(1);
          if (burst_cnt == BURST_LAST) begin
            state_nxt = S_COOL;
            cool_nxt  = COOL_LOAD;
          end
        end
      end
      S_COOL: begin
        if (cool_cnt == '0) state_nxt = S_CPU;
        else                cool_nxt  = cool_cnt - CW'(1);
      end
      default: state_nxt = S_CPU;
    endcase
  end

  // A core write in flight during a grant takes the bus for that cycle.
  always_comb begin
    sel_dma = (state == S_DMA) && !cpu_we;
    dma_ack = sel_dma && dma_req;
  end

  assign mem_addr  = sel_dma ? dma_addr  : cpu_addr;
  assign mem_wdata = sel_dma ? dma_wdata : cpu_wdata;
  // A DMA beat without a live request is an abort: never write memory.
  assign mem_we    = sel_dma ? (dma_we & dma_req) : cpu_we;
  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        ph1;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_we;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:1023];

  mem_bus_arbiter #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .MAX_BURST(4), .COOL_CYCLES(1)
  ) dut (
    .ph1(ph1), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_we(dma_we), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  assign mem_rdata = mem[mem_addr[9:0]];
  always @(posedge ph1) if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;

  function automatic logic [7:0] rom_val(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [15:0] ca;
    logic        cwe;
    logic [7:0]  cwd;
    logic        dreq;
    logic [15:0] da;
    logic        dwe;
    logic [7:0]  dwd;
    logic        e_rdy;
    logic        e_ack;
    logic [15:0] e_addr;
    logic        e_we;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [15:0] ca, input logic cwe,
                              input logic [7:0] cwd, input logic dreq, input logic [15:0] da,
                              input logic dwe, input logic [7:0] dwd, input logic e_rdy,
                              input logic e_ack, input logic [15:0] e_addr, input logic e_we);
    vec_t v;
    v.rst = rst; v.ca = ca; v.cwe = cwe; v.cwd = cwd;
    v.dreq = dreq; v.da = da; v.dwe = dwe; v.dwd = dwd;
    v.e_rdy = e_rdy; v.e_ack = e_ack; v.e_addr = e_addr; v.e_we = e_we;
    return v;
  endfunction

  vec_t vt [16];

  int burst_rdy [17] = '{1,0,0,0,0,1,1,0,0,0,0,1,1,0,0,0,1};
  int burst_ack [17] = '{0,1,1,1,1,0,0,1,1,1,1,0,0,1,1,0,0};

  initial begin
    int  nacks;
    logic ack_seen;

    for (int i = 0; i < 1024; i++) mem[i] = rom_val(i);
    for (int i = 16'h100; i < 16'h200; i++) mem[i] = 8'h00;

    reset = 1'b0; cpu_addr = 16'h1000; cpu_wdata = 8'h00; cpu_we = 1'b0;
    dma_req = 1'b1; dma_addr = 16'h0015; dma_wdata = 8'h7F; dma_we = 1'b1;

    // Reset with request held, single DMA write, then write collision.
    for (int i = 0; i < 5; i++)
      vt[i] = mk(0, 16'h1000, 0, 8'h00, 1, 16'h0015, 1, 8'h7F, 1, 0, 16'h1000, 0);
    vt[5]  = mk(1, 16'h1001, 0, 8'h00, 0, 16'h0015, 1, 8'h7F, 1, 0, 16'h1001, 0);
    vt[6]  = mk(1, 16'h1002, 0, 8'h00, 1, 16'h0015, 1, 8'h7F, 1, 0, 16'h1002, 0);
    vt[7]  = mk(1, 16'h1002, 0, 8'h00, 1, 16'h0015, 1, 8'h7F, 0, 1, 16'h0015, 1);
    vt[8]  = mk(1, 16'h1002, 0, 8'h00, 0, 16'h0015, 1, 8'h7F, 0, 0, 16'h0015, 0);
    vt[9]  = mk(1, 16'h1003, 0, 8'h00, 0, 16'h0015, 1, 8'h7F, 1, 0, 16'h1003, 0);
    vt[10] = mk(1, 16'h1004, 0, 8'h00, 1, 16'h0017, 1, 8'hAA, 1, 0, 16'h1004, 0);
    vt[11] = mk(1, 16'h0016, 1, 8'h55, 1, 16'h0017, 1, 8'hAA, 0, 0, 16'h0016, 1);
    vt[12] = mk(1, 16'h1005, 0, 8'h00, 1, 16'h0017, 1, 8'hAA, 0, 1, 16'h0017, 1);
    vt[13] = mk(1, 16'h1005, 0, 8'h00, 0, 16'h0017, 1, 8'hAA, 0, 0, 16'h0017, 0);
    vt[14] = mk(1, 16'h1006, 0, 8'h00, 1, 16'h0017, 1, 8'hAA, 1, 0, 16'h1006, 0);
    vt[15] = mk(1, 16'h1007, 0, 8'h00, 0, 16'h0017, 1, 8'hAA, 1, 0, 16'h1007, 0);

    for (int i = 0; i < 16; i++) begin
      @(posedge ph1); #1;
      reset = vt[i].rst; cpu_addr = vt[i].ca; cpu_we = vt[i].cwe; cpu_wdata = vt[i].cwd;
      dma_req = vt[i].dreq; dma_addr = vt[i].da; dma_we = vt[i].dwe; dma_wdata = vt[i].dwd;
      @(negedge ph1);
      chk($sformatf("vec%0d cpu_rdy", i), 32'(cpu_rdy), 32'(vt[i].e_rdy));
      chk($sformatf("vec%0d dma_ack", i), 32'(dma_ack), 32'(vt[i].e_ack));
      chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(vt[i].e_addr));
      chk($sformatf("vec%0d mem_we", i), 32'(mem_we), 32'(vt[i].e_we));
      chk($sformatf("vec%0d mem_wdata", i), 32'(mem_wdata),
          32'(vt[i].e_addr == vt[i].ca ? vt[i].cwd : vt[i].dwd));
      chk($sformatf("vec%0d cpu_rdata", i), 32'(cpu_rdata), 32'(mem[vt[i].e_addr[9:0]]));
    end
    chk("ram21 dma write", 32'(mem[16'h15]), 32'h7F);
    chk("ram22 cpu write", 32'(mem[16'h16]), 32'h55);
    chk("ram23 dma after collision", 32'(mem[16'h17]), 32'hAA);

    // Burst cap: 10 reads from 0x0200, groups of 4,4,2 with cool-down gaps.
    cpu_we = 1'b0; dma_we = 1'b0; dma_addr = 16'h0200; dma_wdata = 8'h00;
    nacks = 0; ack_seen = 1'b0;
    for (int c = 0; c < 17; c++) begin
      @(posedge ph1); #1;
      if (ack_seen) begin
        nacks++;
        dma_addr = dma_addr + 16'd1;
      end
      cpu_addr = 16'h1100 + 16'(c);
      dma_req = (nacks < 10);
      @(negedge ph1);
      ack_seen = dma_ack;
      chk($sformatf("burst c%0d cpu_rdy", c), 32'(cpu_rdy), 32'(burst_rdy[c]));
      chk($sformatf("burst c%0d dma_ack", c), 32'(dma_ack), 32'(burst_ack[c]));
      if (dma_ack)
        chk($sformatf("burst c%0d dma_rdata", c), 32'(dma_rdata), 32'(rom_val(int'(dma_addr))));
    end
    chk("burst total acks", 32'(nacks), 32'd10);

    // Reset mid-burst: reset after the 2nd of 4 write beats.
    @(posedge ph1); #1;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0100; dma_wdata = 8'hC0;
    @(negedge ph1);
    chk("rmb grant cycle rdy", 32'(cpu_rdy), 32'd1);
    @(posedge ph1); #1;
    @(negedge ph1);
    chk("rmb ack1", 32'(dma_ack), 32'd1);
    @(posedge ph1); #1;
    dma_addr = 16'h0101; dma_wdata = 8'hC1;
    @(negedge ph1);
    chk("rmb ack2", 32'(dma_ack), 32'd1);
    @(posedge ph1); #1;
    dma_addr = 16'h0102; dma_wdata = 8'hC2;
    reset = 1'b0;
    #1;
    chk("rmb reset cpu_rdy", 32'(cpu_rdy), 32'd1);
    chk("rmb reset dma_ack", 32'(dma_ack), 32'd0);
    chk("rmb reset mem_addr", 32'(mem_addr), 32'(cpu_addr));
    chk("rmb reset mem_we", 32'(mem_we), 32'd0);
    @(posedge ph1); #1;
    reset = 1'b1; dma_req = 1'b0;
    @(negedge ph1);
    chk("rmb after release rdy", 32'(cpu_rdy), 32'd1);
    chk("rmb ram100", 32'(mem[16'h100]), 32'hC0);
    chk("rmb ram101", 32'(mem[16'h101]), 32'hC1);
    chk("rmb ram102 untouched", 32'(mem[16'h102]), 32'h00);
    chk("rmb ram103 untouched", 32'(mem[16'h103]), 32'h00);

    // CPU-only traffic: rdy stays high, core writes land.
    for (int i = 0; i < 8; i++) begin
      @(posedge ph1); #1;
      cpu_addr = 16'h0030 + 16'(i); cpu_we = 1'b1; cpu_wdata = 8'h40 + 8'(i);
      @(negedge ph1);
      chk($sformatf("cpuonly%0d rdy", i), 32'(cpu_rdy), 32'd1);
      chk($sformatf("cpuonly%0d mem_addr", i), 32'(mem_addr), 32'h0030 + 32'(i));
    end
    @(posedge ph1); #1;
    cpu_we = 1'b0;
    for (int i = 0; i < 8; i++)
      chk($sformatf("cpuonly ram%0d", i), 32'(mem[16'h30 + i]), 32'h40 + 32'(i));
    chk("ram21 retained", 32'(mem[16'h15]), 32'h7F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
